// File: rtl/serial_tx_pkg.sv
// Shared state encoding and line levels for the framed serial word transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-time down-counter: reloads on clear and flags the last cycle of each bit-time.
module serial_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic bit_end_o,
  output logic bit_penult_o
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bit_end_o    = (cnt_q == '0);
  // Only reachable when BIT_CYCLES > 1; lets the FSM register done one cycle early.
  assign bit_penult_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/serial_word_tx.sv
// Framed MSB-first serial word transmitter with valid/ready input and registered line outputs.
// Optional even-parity bit after the data bits when SERIAL_TX_PARITY_EN is defined.
module serial_word_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH);

  tx_state_t        state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic             out_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_q;
`endif

  logic accept;
  logic last_bit;
  logic bit_end;
  logic bit_penult;
  logic timer_clear;

  assign accept      = (state_q == IDLE) && valid && ready_q;
  assign last_bit    = (bit_cnt_q == BIT_W'(WIDTH - 1));
  assign timer_clear = accept || ((state_q != IDLE) && bit_end);

  serial_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (timer_clear),
    .bit_end_o    (bit_end),
    .bit_penult_o (bit_penult)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      out_q     <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= data_in;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^data_in;
`endif
            state_q <= START;
            out_q   <= LINE_START;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            out_q   <= shift_q[WIDTH-1];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            if (last_bit) begin
              bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state_q <= PARITY;
              out_q   <= parity_q;
`else
              state_q <= STOP;
              out_q   <= LINE_STOP;
              done_q  <= (BIT_CYCLES == 1);
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              out_q     <= shift_q[WIDTH-2];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            out_q   <= LINE_STOP;
            done_q  <= (BIT_CYCLES == 1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            out_q   <= LINE_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (bit_penult) begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= LINE_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign out   = out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: table of words with hand-written frames plus multi-cycle corner sequences.
module tb_serial_word_tx;

  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FLEN = W + 2 + P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       rdy0, out0, busy0, done0;
  logic       rdy1, out1, busy1, done1;

  serial_word_tx #(.WIDTH(W), .BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst), .data_in(d0), .valid(v0),
    .ready(rdy0), .out(out0), .busy(busy0), .done(done0)
  );

  serial_word_tx #(.WIDTH(W), .BIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst), .data_in(d1), .valid(v1),
    .ready(rdy1), .out(out1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // start, data MSB first, stop
    logic       par;
  } vec_t;

  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [9:0] frame, input logic par, input int i);
    if (i < 9) return frame[9-i];
    if (P == 1 && i == 9) return par;
    return 1'b0;
  endfunction

  task automatic accept0(input logic [7:0] d);
    @(negedge clk);
    d0 = d;
    v0 = 1'b1;
  endtask

  task automatic frame0(input logic [9:0] frame, input logic par, input int inj, input bit keep);
    for (int i = 0; i < FLEN; i++) begin
      @(negedge clk);
      chk($sformatf("out[%0d]", i), out0, exp_bit(frame, par, i));
      chk($sformatf("done[%0d]", i), done0, (i == FLEN - 1));
      chk($sformatf("ready[%0d]", i), rdy0, 1'b0);
      chk($sformatf("busy[%0d]", i), busy0, 1'b1);
      if (done0) done_seen++;
      if (i == 0 && !keep) v0 = 1'b0;
      if (inj >= 0 && i == inj) begin
        d0 = 8'h3C;
        v0 = 1'b1;
      end else if (inj >= 0 && i == inj + 1) begin
        v0 = 1'b0;
      end
    end
    @(negedge clk);
    chk("idle_out", out0, 1'b0);
    chk("idle_ready", rdy0, 1'b1);
    chk("idle_busy", busy0, 1'b0);
    chk("idle_done", done0, 1'b0);
    if (done0) done_seen++;
  endtask

  initial begin
    tbl[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    tbl[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
    tbl[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    tbl[3] = '{8'h00, 10'b1_00000000_0, 1'b0};
    tbl[4] = '{8'h81, 10'b1_10000001_0, 1'b0};
    tbl[5] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    tbl[6] = '{8'h01, 10'b1_00000001_0, 1'b1};
    tbl[7] = '{8'hE0, 10'b1_11100000_0, 1'b1};

    rst = 1'b1;
    d0 = '0; v0 = 1'b0;
    d1 = '0; v1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out0", out0, 1'b0);
    chk("rst_ready0", rdy0, 1'b1);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_done0", done0, 1'b0);
    chk("rst_out1", out1, 1'b0);
    chk("rst_ready1", rdy1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_done1", done1, 1'b0);
    rst = 1'b0;

    // Table of single-word frames, one-cycle valid each.
    for (int k = 0; k < 8; k++) begin
      accept0(tbl[k].data);
      frame0(tbl[k].frame, tbl[k].par, -1, 1'b0);
    end

    // Word 0x3C offered mid-frame must not disturb 0xA5 nor start a new frame.
    accept0(8'hA5);
    frame0(tbl[0].frame, tbl[0].par, 3, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("ignored_out", out0, 1'b0);
      chk("ignored_ready", rdy0, 1'b1);
    end

    // Reset during data bit 3 of 0xFF.
    done_seen = 0;
    accept0(8'hFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_out[%0d]", i), out0, exp_bit(tbl[2].frame, 1'b0, i));
      if (i == 0) v0 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_out", out0, 1'b0);
    chk("rstmid_ready", rdy0, 1'b1);
    chk("rstmid_busy", busy0, 1'b0);
    chk("rstmid_done", done0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_out[%0d]", i), out0, 1'b0);
      if (done0) done_seen++;
    end
    chk("post_rst_done_count", done_seen, 0);
    accept0(8'h81);
    frame0(tbl[4].frame, tbl[4].par, -1, 1'b0);

    // Back-to-back with valid held: one idle cycle between frames, two done pulses.
    done_seen = 0;
    accept0(8'h55);
    frame0(10'b1_01010101_0, 1'b0, -1, 1'b1);
    d0 = 8'hAA;
    frame0(10'b1_10101010_0, 1'b0, -1, 1'b1);
    v0 = 1'b0;
    chk("b2b_done_count", done_seen, 2);
    @(negedge clk);
    chk("b2b_tail_ready", rdy0, 1'b1);
    chk("b2b_tail_out", out0, 1'b0);

    // BIT_CYCLES=3 instance, word 0x01.
    @(negedge clk);
    d1 = 8'h01;
    v1 = 1'b1;
    for (int i = 0; i < 3 * FLEN; i++) begin
      @(negedge clk);
      chk($sformatf("bc3_out[%0d]", i), out1, exp_bit(tbl[6].frame, 1'b1, i / 3));
      chk($sformatf("bc3_done[%0d]", i), done1, (i == 3 * FLEN - 1));
      chk($sformatf("bc3_busy[%0d]", i), busy1, 1'b1);
      if (i == 0) v1 = 1'b0;
    end
    @(negedge clk);
    chk("bc3_idle_ready", rdy1, 1'b1);
    chk("bc3_idle_out", out1, 1'b0);
    chk("bc3_idle_done", done1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Single-line serial transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a one-bit line as a framed bit stream. It is the driving end of the team's single-bit serial inputs: it produces the `in` stream a serial receiver or sequence detector consumes, so stimulus is generated in hardware rather than by hand-timed bench delays. It sits between a parallel producer, such as a register or CPU store port, and the serial consumer.

## Interface
- WIDTH, 8: data word width in bits; must be at least 2.
- BIT_CYCLES, 1: clock cycles each serial bit is held; must be at least 1.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only on handshake.
- valid  input  1  producer has a word on data_in.
- ready  output  1  transmitter is idle and accepts a word.
- out  output  1  serial line.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse on the last cycle of a frame.

## Operation
- States:
  - IDLE: out=0, ready=1, busy=0.
  - START: out=1.
  - DATA: out=shift_reg[WIDTH-1], so bits leave MSB first.
  - PARITY: present only with the macro.
  - STOP: out=0.
- Handshake: the word is accepted when valid && ready at a rising edge in IDLE. data_in is latched into shift_reg and the FSM moves to START.
- valid in any non-IDLE state is ignored. data_in changes mid-frame have no effect.
- Each state holds for BIT_CYCLES cycles, timed by a cycle counter that is cleared on every state entry.
- DATA runs exactly WIDTH bit-times. A bit counter runs 0..WIDTH-1, and shift_reg shifts left with 0 fill at the end of each bit-time.
- Transitions:
  - START -> DATA.
  - DATA -> PARITY when the macro is enabled, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- done=1 only during the final cycle of STOP.
- Frame length: (WIDTH + 2 + P) * BIT_CYCLES cycles, where P=1 with parity and 0 without.
- Reset values: state=IDLE, out=0, ready=1, busy=0, done=0, shift_reg=0, both counters 0.
- Reset mid-frame: on the cycle after reset is sampled high, the line is back at idle (out=0), the frame is abandoned and no done pulse is produced. Reset takes priority over a simultaneous handshake.
- Counter widths: bit counter is $clog2(WIDTH) bits; cycle counter is max(1, $clog2(BIT_CYCLES)) bits. No counter wraps except by an explicit clear.

## Timing
- Handshake at edge k: out=1 (start bit) from cycle k+1. The first data bit appears at cycle k+1+BIT_CYCLES.
- ready drops in the cycle after acceptance. It returns in the cycle after the done cycle.
- Back-to-back: with valid held high, the next word is accepted on the first IDLE cycle. This gives exactly one idle-low cycle between frames.
- out, ready, busy and done are registered (driven from state and counters), with no combinational path from the inputs.

## Configuration
- SERIAL_TX_PARITY_EN:
  - Defined: an even-parity bit is sent after the data bits for one bit-time. Its value is the XOR of the latched WIDTH data bits, computed at latch time and stored, so the total count of ones in data plus parity is even.
  - Undefined: the PARITY state and parity register are absent, and DATA goes directly to STOP.

## Structure
- Package serial_tx_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the constants LINE_IDLE=1'b0, LINE_START=1'b1, LINE_STOP=1'b0.
- One sub-module, serial_bit_timer: a parameterised BIT_CYCLES down-counter with a clear input and a bit_end pulse output. The FSM advances only on bit_end.

## Test plan
- WIDTH=8, BIT_CYCLES=1, no parity, data_in=0xA5 with a one-cycle valid: out = 1,1,0,1,0,0,1,0,1,0 over 10 cycles. done is high on cycle 10, ready is high again on cycle 11.
- BIT_CYCLES=3, data_in=0x01: the start bit is high for 3 cycles, then 21 cycles low, then the last data bit high for 3 cycles, then the stop bit low for 3 cycles. Total 30 cycles.
- Parity enabled, WIDTH=8, BIT_CYCLES=1:
  - 0x07 gives parity bit 1 and a frame length of 11.
  - 0xA5 gives parity bit 0.
- Reset asserted during data bit 3 of 0xFF: the next cycle shows out=0, ready=1, busy=0, and no done pulse is produced. A new word 0x81 accepted afterwards transmits correctly.
- valid pulsed with 0x3C while busy sending 0xA5: 0x3C is ignored and the output frame is unchanged.
- valid held high with 0x55 then 0xAA: two frames with exactly one idle-low cycle between them, and exactly two done pulses.
